// File: rtl/llc_inflight_set_queue_pkg.sv
// Shared constants, kind codes and entry layout for the LLC in-flight set queue.
// Optional statistics counters are enabled with `define LLC_INFLIGHT_STATS_EN.
package llc_inflight_set_queue_pkg;

  // cache_consts: default geometry of the LLC front end
  localparam int LLC_SET_BITS  = 8;
  localparam int LLC_TAG_BITS  = 12;
  localparam int LLC_KIND_BITS = 3;
  localparam int LLC_DEPTH     = 4;

  typedef enum logic [2:0] {
    LLC_KIND_REQ   = 3'd0,
    LLC_KIND_DMA   = 3'd1,
    LLC_KIND_RSP   = 3'd2,
    LLC_KIND_RST   = 3'd3,
    LLC_KIND_FLUSH = 3'd4
  } llc_kind_e;

  typedef struct packed {
    logic [LLC_SET_BITS-1:0]  set_idx;
    logic [LLC_TAG_BITS-1:0]  tag;
    logic [LLC_KIND_BITS-1:0] kind;
  } inflight_entry_t;

  function automatic int llc_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Global operations must run alone in an otherwise empty pipeline.
  function automatic logic llc_kind_is_global(input logic [31:0] k);
    return (k == {29'd0, LLC_KIND_RST}) || (k == {29'd0, LLC_KIND_FLUSH});
  endfunction

  function automatic logic llc_kind_is_rsp(input logic [31:0] k);
    return (k == {29'd0, LLC_KIND_RSP});
  endfunction

endpackage

// File: rtl/llc_inflight_set_queue_if.sv
// Decoder-side, lookup-side and retire signals of the in-flight set queue.
// Statistics signals exist only when LLC_INFLIGHT_STATS_EN is defined.
interface llc_inflight_set_queue_if #(
  parameter int SET_BITS  = 8,
  parameter int TAG_BITS  = 12,
  parameter int DEPTH     = 4,
  parameter int KIND_BITS = 3
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid never waits on ready, ready may depend on valid's payload.
  logic                 in_valid;
  logic                 in_ready;
  logic [SET_BITS-1:0]  in_set;
  logic [TAG_BITS-1:0]  in_tag;
  logic [KIND_BITS-1:0] in_kind;
  logic                 out_valid;
  logic                 out_ready;
  logic [SET_BITS-1:0]  out_set;
  logic [TAG_BITS-1:0]  out_tag;
  logic [KIND_BITS-1:0] out_kind;
  logic                 retire_valid;
  logic [CW-1:0]        count;
  logic                 hazard_stall;
  logic                 retire_err;
`ifdef LLC_INFLIGHT_STATS_EN
  logic                 stat_clr;
  logic [15:0]          stat_hazard_cycles;
  logic [15:0]          stat_full_cycles;

  modport master (
    output in_valid, in_set, in_tag, in_kind, out_ready, retire_valid, stat_clr,
    input  in_ready, out_valid, out_set, out_tag, out_kind, count, hazard_stall,
           retire_err, stat_hazard_cycles, stat_full_cycles
  );
  modport slave (
    input  in_valid, in_set, in_tag, in_kind, out_ready, retire_valid, stat_clr,
    output in_ready, out_valid, out_set, out_tag, out_kind, count, hazard_stall,
           retire_err, stat_hazard_cycles, stat_full_cycles
  );
`else
  modport master (
    output in_valid, in_set, in_tag, in_kind, out_ready, retire_valid,
    input  in_ready, out_valid, out_set, out_tag, out_kind, count, hazard_stall,
           retire_err
  );
  modport slave (
    input  in_valid, in_set, in_tag, in_kind, out_ready, retire_valid,
    output in_ready, out_valid, out_set, out_tag, out_kind, count, hazard_stall,
           retire_err
  );
`endif
endinterface

// File: rtl/llc_inflight_set_queue_set_match.sv
// DEPTH-way set comparator: per-entry match vector plus a flag that any
// occupied entry is a global operation (RST/FLUSH).
module llc_set_match
  import llc_inflight_set_queue_pkg::*;
#(
  parameter int SET_BITS  = 8,
  parameter int KIND_BITS = 3,
  parameter int DEPTH     = 4
) (
  input  logic [DEPTH-1:0][SET_BITS-1:0]  i_sets,
  input  logic [DEPTH-1:0][KIND_BITS-1:0] i_kinds,
  input  logic [DEPTH-1:0]                i_valid,
  input  logic [SET_BITS-1:0]             i_set,
  output logic [DEPTH-1:0]                o_match,
  output logic                            o_global_pending
);

  always_comb begin
    o_match          = '0;
    o_global_pending = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      o_match[k] = i_valid[k] && (i_sets[k] == i_set);
      if (i_valid[k] && llc_kind_is_global(32'(i_kinds[k]))) begin
        o_global_pending = 1'b1;
      end
    end
  end

endmodule

// File: rtl/llc_inflight_set_queue.sv
// Multi-entry admission queue between the LLC decoder and lookup pipeline with
// set-hazard blocking. Define LLC_INFLIGHT_STATS_EN to add stall statistics.
module llc_inflight_set_queue
  import llc_inflight_set_queue_pkg::*;
#(
  parameter int SET_BITS  = LLC_SET_BITS,
  parameter int TAG_BITS  = LLC_TAG_BITS,
  parameter int DEPTH     = LLC_DEPTH,
  parameter int KIND_BITS = LLC_KIND_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  llc_inflight_set_queue_if.slave  bus
);

  localparam int            PW      = llc_ptr_w(DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [SET_BITS-1:0]  set_idx;
    logic [TAG_BITS-1:0]  tag;
    logic [KIND_BITS-1:0] kind;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_iss_ptr;
  logic [PW-1:0] r_ret_ptr;
  logic [CW-1:0] r_n_q;
  logic [CW-1:0] r_n_i;
  logic          r_retire_err;

  logic [DEPTH-1:0][SET_BITS-1:0]  w_sets;
  logic [DEPTH-1:0][KIND_BITS-1:0] w_kinds;
  logic [PW-1:0]                   w_offs [DEPTH];
  logic [DEPTH-1:0]                w_occupied;
  logic [DEPTH-1:0]                w_match;
  logic                            w_global_pending;
  logic [CW-1:0]                   w_count;
  logic                            w_not_full;
  logic                            w_kind_global;
  logic                            w_kind_rsp;
  logic                            w_in_ready;
  logic                            w_hazard_stall;
  logic                            w_accept;
  logic                            w_issue;
  logic                            w_retire;
  entry_t                          w_head;
  entry_t                          w_new;

  // Occupied entries run from ret_ptr for count slots; hazards cover both
  // queued and issued entries, including one retiring this very cycle.
  always_comb begin
    w_count = r_n_q + r_n_i;
    for (int k = 0; k < DEPTH; k++) begin
      w_sets[k]      = r_mem[k].set_idx;
      w_kinds[k]     = r_mem[k].kind;
      w_offs[k]      = PW'(k) - r_ret_ptr;
      w_occupied[k]  = ({1'b0, w_offs[k]} < w_count);
    end
  end

  llc_set_match #(
    .SET_BITS  (SET_BITS),
    .KIND_BITS (KIND_BITS),
    .DEPTH     (DEPTH)
  ) u_set_match (
    .i_sets           (w_sets),
    .i_kinds          (w_kinds),
    .i_valid          (w_occupied),
    .i_set            (bus.in_set),
    .o_match          (w_match),
    .o_global_pending (w_global_pending)
  );

  assign w_not_full    = (w_count < DEPTH_C);
  assign w_kind_global = llc_kind_is_global(32'(bus.in_kind));
  assign w_kind_rsp    = llc_kind_is_rsp(32'(bus.in_kind));

  // Responses skip the set check: they resolve the pending set and must not block.
  always_comb begin
    w_in_ready = 1'b0;
    if (rst && w_not_full && !w_global_pending) begin
      if (w_kind_global) begin
        w_in_ready = (w_count == '0);
      end else if (w_kind_rsp) begin
        w_in_ready = 1'b1;
      end else begin
        w_in_ready = ~|w_match;
      end
    end
  end

  assign w_hazard_stall = rst && bus.in_valid && !w_in_ready && w_not_full;
  assign w_accept       = bus.in_valid && w_in_ready;
  assign w_issue        = (r_n_q != '0) && bus.out_ready;
  assign w_retire       = bus.retire_valid && (r_n_i != '0);
  assign w_head         = r_mem[r_iss_ptr];

  always_comb begin
    w_new         = '0;
    w_new.set_idx = bus.in_set;
    w_new.tag     = bus.in_tag;
    w_new.kind    = bus.in_kind;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
      r_wr_ptr     <= '0;
      r_iss_ptr    <= '0;
      r_ret_ptr    <= '0;
      r_n_q        <= '0;
      r_n_i        <= '0;
      r_retire_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr] <= w_new;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_issue) begin
        r_iss_ptr <= r_iss_ptr + 1'b1;
      end
      if (w_retire) begin
        r_ret_ptr <= r_ret_ptr + 1'b1;
      end
      r_n_q <= r_n_q + CW'(w_accept) - CW'(w_issue);
      r_n_i <= r_n_i + CW'(w_issue) - CW'(w_retire);
      if (bus.retire_valid && (r_n_i == '0)) begin
        r_retire_err <= 1'b1;
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = (r_n_q != '0);
  assign bus.out_set      = w_head.set_idx;
  assign bus.out_tag      = w_head.tag;
  assign bus.out_kind     = w_head.kind;
  assign bus.count        = w_count;
  assign bus.hazard_stall = w_hazard_stall;
  assign bus.retire_err   = r_retire_err;

`ifdef LLC_INFLIGHT_STATS_EN
  logic [15:0] r_stat_hazard;
  logic [15:0] r_stat_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_hazard <= '0;
      r_stat_full   <= '0;
    end else if (bus.stat_clr) begin
      r_stat_hazard <= '0;
      r_stat_full   <= '0;
    end else begin
      if (w_hazard_stall && (r_stat_hazard != 16'hFFFF)) begin
        r_stat_hazard <= r_stat_hazard + 16'd1;
      end
      if (bus.in_valid && (w_count == DEPTH_C) && (r_stat_full != 16'hFFFF)) begin
        r_stat_full <= r_stat_full + 16'd1;
      end
    end
  end

  assign bus.stat_hazard_cycles = r_stat_hazard;
  assign bus.stat_full_cycles   = r_stat_full;
`endif

endmodule
